alu_exec_sequencer: RTL and testbench

- Drives the combinational ALU from the other side of its interface.
- Accepts one decoded RV32I instruction per handshake and translates opcode/funct3/funct7[5] into the 4-bit ALU select.
- Steers operands into the ALU and registers `result`/`bool` into an output holding register.
- Sequences branches over two ALU passes: compare, then target add. Sits between register read and writeback/PC-update in the multi-cycle core variant.

---
 rtl/alu_pkg.sv | 68 ++++++
 rtl/alu_exec_sequencer_if.sv | 56 +++++
 rtl/exec_decode.sv | 76 +++++++
 rtl/alu_exec_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU / execute-sequencer definitions: ALU select codes, RV32I opcodes,
// sequencer state encoding, operand routing and the arithmetic funct3 mapping.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SLL = 4'h5,
        ALU_SRL = 4'h6,
        ALU_SRA = 4'h7,
        ALU_BEQ = 4'h8,
        ALU_BNE = 4'h9,
        ALU_BGE = 4'hA,
        ALU_BLT = 4'hB
    } alu_sel_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_BR_TGT = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

    typedef enum logic [1:0] {
        RS1_RS2  = 2'd0,
        RS1_IMM  = 2'd1,
        ZERO_IMM = 2'd2,
        PC_IMM   = 2'd3
    } op_sel_e;

    // sub_en turns ADD into SUB, sra_en turns SRL into SRA; slt/sltu map to ADD here.
    function automatic alu_sel_e arith_sel(input logic [2:0] funct3, input logic sub_en,
                                           input logic sra_en);
        alu_sel_e sel_s;
        case (funct3)
            3'b000: begin
                if (sub_en) sel_s = ALU_SUB;
                else        sel_s = ALU_ADD;
            end
            3'b001: sel_s = ALU_SLL;
            3'b100: sel_s = ALU_XOR;
            3'b101: begin
                if (sra_en) sel_s = ALU_SRA;
                else        sel_s = ALU_SRL;
            end
            3'b110: sel_s = ALU_OR;
            3'b111: sel_s = ALU_AND;
            default: sel_s = ALU_ADD;
        endcase
        return sel_s;
    endfunction

    function automatic logic arith_f3_illegal(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

endpackage

// File: rtl/alu_exec_sequencer_if.sv
// Instruction-in, result-out and ALU-side signals of alu_exec_sequencer.
// Build option EXEC_ILLEGAL_TRAP_EN adds the out_illegal flag.
interface alu_exec_sequencer_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      in_opcode;
    logic [2:0]      in_funct3;
    logic            in_funct7_5;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_imm;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] alu_result;
    logic            alu_bool;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_wr_en;
    logic            out_br_taken;
`ifdef EXEC_ILLEGAL_TRAP_EN
    logic            out_illegal;
`endif

    // Sequencer side.
    modport slave (
`ifdef EXEC_ILLEGAL_TRAP_EN
        output out_illegal,
`endif
        input  in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm, in_pc, in_rd,
        output in_ready,
        output alu_a, alu_b, alu_sel,
        input  alu_result, alu_bool,
        output out_valid, out_result, out_rd, out_wr_en, out_br_taken,
        input  out_ready
    );

    // Instruction source, result consumer and the combinational ALU.
    modport master (
`ifdef EXEC_ILLEGAL_TRAP_EN
        input  out_illegal,
`endif
        output in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1, in_rs2, in_imm, in_pc, in_rd,
        input  in_ready,
        input  alu_a, alu_b, alu_sel,
        output alu_result, alu_bool,
        input  out_valid, out_result, out_rd, out_wr_en, out_br_taken,
        output out_ready
    );
endinterface

// File: rtl/exec_decode.sv
// Combinational RV32I decode into ALU select, operand routing and writeback class.
// wr_en is the raw class value; the sequencer applies the illegal-instruction policy.
module exec_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output alu_sel_e   alu_sel,
    output op_sel_e    op_sel,
    output logic       is_branch,
    output logic       wr_en,
    output logic       illegal
);
    alu_sel_e sel_s;
    op_sel_e  op_sel_s;
    logic     branch_s;
    logic     wr_s;
    logic     illegal_s;

    // Opcode class decode; anything not recognised is flagged illegal.
    always_comb begin
        sel_s     = ALU_ADD;
        op_sel_s  = RS1_RS2;
        branch_s  = 1'b0;
        wr_s      = 1'b0;
        illegal_s = 1'b0;
        case (opcode)
            OPC_OP: begin
                sel_s     = arith_sel(funct3, funct7_5, funct7_5);
                wr_s      = 1'b1;
                illegal_s = arith_f3_illegal(funct3);
            end
            OPC_OP_IMM: begin
                sel_s     = arith_sel(funct3, 1'b0, funct7_5);
                op_sel_s  = RS1_IMM;
                wr_s      = 1'b1;
                illegal_s = arith_f3_illegal(funct3);
            end
            OPC_LOAD, OPC_JALR: begin
                op_sel_s = RS1_IMM;
                wr_s     = 1'b1;
            end
            OPC_STORE: op_sel_s = RS1_IMM;
            OPC_LUI: begin
                op_sel_s = ZERO_IMM;
                wr_s     = 1'b1;
            end
            OPC_BRANCH: begin
                branch_s = 1'b1;
                case (funct3)
                    3'b000:  sel_s = ALU_BEQ;
                    3'b001:  sel_s = ALU_BNE;
                    3'b100:  sel_s = ALU_BLT;
                    3'b101:  sel_s = ALU_BGE;
                    default: illegal_s = 1'b1;
                endcase
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // Illegal encodings always execute as a single-pass ADD.
    always_comb begin
        op_sel  = op_sel_s;
        wr_en   = wr_s;
        illegal = illegal_s;
        if (illegal_s) begin
            alu_sel   = ALU_ADD;
            is_branch = 1'b0;
        end else begin
            alu_sel   = sel_s;
            is_branch = branch_s;
        end
    end
endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute sequencer: one instruction per handshake, one ALU pass (two for branches),
// result held until consumed. Build option EXEC_ILLEGAL_TRAP_EN adds out_illegal.
module alu_exec_sequencer
    import alu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input logic                 clk,
    input logic                 rst_n,
    alu_exec_sequencer_if.slave bus
);
    seq_state_e      state_r;
    seq_state_e      next_state_s;
    alu_sel_e        dec_sel_s;
    op_sel_e         dec_op_sel_s;
    logic            dec_branch_s;
    logic            dec_wr_en_s;
    logic            dec_illegal_s;
    logic            wr_en_s;
    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op_b_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] imm_r;
    logic [4:0]      rd_r;
    logic            branch_r;
    logic            wr_en_r;
    alu_sel_e        alu_sel_r;
    logic [XLEN-1:0] alu_a_r;
    logic [XLEN-1:0] alu_b_r;
    logic            out_valid_r;
    logic [XLEN-1:0] out_result_r;
    logic [4:0]      out_rd_r;
    logic            out_wr_en_r;
    logic            out_br_taken_r;
`ifdef EXEC_ILLEGAL_TRAP_EN
    logic            illegal_r;
    logic            out_illegal_r;
`endif

    exec_decode u_decode (
        .opcode    (bus.in_opcode),
        .funct3    (bus.in_funct3),
        .funct7_5  (bus.in_funct7_5),
        .alu_sel   (dec_sel_s),
        .op_sel    (dec_op_sel_s),
        .is_branch (dec_branch_s),
        .wr_en     (dec_wr_en_s),
        .illegal   (dec_illegal_s)
    );

    // First-pass operand routing from the incoming instruction.
    always_comb begin
        op_a_s = bus.in_rs1;
        op_b_s = bus.in_rs2;
        case (dec_op_sel_s)
            RS1_RS2:  op_b_s = bus.in_rs2;
            RS1_IMM:  op_b_s = bus.in_imm;
            ZERO_IMM: begin
                op_a_s = {XLEN{1'b0}};
                op_b_s = bus.in_imm;
            end
            PC_IMM: begin
                op_a_s = bus.in_pc;
                op_b_s = bus.in_imm;
            end
            default: op_b_s = bus.in_rs2;
        endcase
    end

    // Writeback policy for illegal instructions.
    always_comb begin
        if (dec_illegal_s) begin
`ifdef EXEC_ILLEGAL_TRAP_EN
            wr_en_s = 1'b0;
`else
            wr_en_s = ~ILLEGAL_AS_NOP;
`endif
        end else begin
            wr_en_s = dec_wr_en_s;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= next_state_s;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid) next_state_s = ST_EXEC;
                else              next_state_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (branch_r) next_state_s = ST_BR_TGT;
                else          next_state_s = ST_DONE;
            end
            ST_BR_TGT: next_state_s = ST_DONE;
            ST_DONE: begin
                if (bus.out_ready) next_state_s = ST_IDLE;
                else               next_state_s = ST_DONE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Capture at acceptance, ALU port staging and the output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r           <= {XLEN{1'b0}};
            imm_r          <= {XLEN{1'b0}};
            rd_r           <= 5'd0;
            branch_r       <= 1'b0;
            wr_en_r        <= 1'b0;
            alu_sel_r      <= ALU_ADD;
            alu_a_r        <= {XLEN{1'b0}};
            alu_b_r        <= {XLEN{1'b0}};
            out_valid_r    <= 1'b0;
            out_result_r   <= {XLEN{1'b0}};
            out_rd_r       <= 5'd0;
            out_wr_en_r    <= 1'b0;
            out_br_taken_r <= 1'b0;
`ifdef EXEC_ILLEGAL_TRAP_EN
            illegal_r      <= 1'b0;
            out_illegal_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        pc_r      <= bus.in_pc;
                        imm_r     <= bus.in_imm;
                        rd_r      <= bus.in_rd;
                        branch_r  <= dec_branch_s;
                        wr_en_r   <= wr_en_s;
                        alu_sel_r <= dec_sel_s;
                        alu_a_r   <= op_a_s;
                        alu_b_r   <= op_b_s;
`ifdef EXEC_ILLEGAL_TRAP_EN
                        illegal_r <= dec_illegal_s;
`endif
                    end
                end
                ST_EXEC: begin
                    if (branch_r) begin
                        // Compare flag now, target add on the second pass.
                        out_br_taken_r <= bus.alu_bool;
                        alu_sel_r      <= ALU_ADD;
                        alu_a_r        <= pc_r;
                        alu_b_r        <= imm_r;
                    end else begin
                        out_br_taken_r <= 1'b0;
                        out_result_r   <= bus.alu_result;
                        out_rd_r       <= rd_r;
                        out_wr_en_r    <= wr_en_r;
                        out_valid_r    <= 1'b1;
`ifdef EXEC_ILLEGAL_TRAP_EN
                        out_illegal_r  <= illegal_r;
`endif
                    end
                end
                ST_BR_TGT: begin
                    out_result_r  <= bus.alu_result;
                    out_rd_r      <= rd_r;
                    out_wr_en_r   <= wr_en_r;
                    out_valid_r   <= 1'b1;
`ifdef EXEC_ILLEGAL_TRAP_EN
                    out_illegal_r <= illegal_r;
`endif
                end
                ST_DONE: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: out_valid_r <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready     = (state_r == ST_IDLE);
    assign bus.alu_sel      = alu_sel_r;
    assign bus.alu_a        = alu_a_r;
    assign bus.alu_b        = alu_b_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.out_result   = out_result_r;
    assign bus.out_rd       = out_rd_r;
    assign bus.out_wr_en    = out_wr_en_r;
    assign bus.out_br_taken = out_br_taken_r;
`ifdef EXEC_ILLEGAL_TRAP_EN
    assign bus.out_illegal  = out_illegal_r;
`endif
endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench for alu_exec_sequencer: directed vector table, reset/backpressure
// sequences and randomized instructions checked against an RV32I-level reference model.
module tb_alu_exec_sequencer;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        int          hold;
        logic [3:0]  sel;
        logic [31:0] res;
        logic        wr;
        logic        tk;
        logic        br;
        logic        ill;
    } vec_t;

    alu_exec_sequencer_if #(.XLEN(32)) bus ();

    alu_exec_sequencer #(.XLEN(32), .ILLEGAL_AS_NOP(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the combinational ALU on the far side of the interface.
    always_comb begin
        bus.alu_result = 32'h0;
        bus.alu_bool   = 1'b0;
        case (bus.alu_sel)
            4'h0: bus.alu_result = bus.alu_a + bus.alu_b;
            4'h1: bus.alu_result = bus.alu_a - bus.alu_b;
            4'h2: bus.alu_result = bus.alu_a & bus.alu_b;
            4'h3: bus.alu_result = bus.alu_a | bus.alu_b;
            4'h4: bus.alu_result = bus.alu_a ^ bus.alu_b;
            4'h5: bus.alu_result = bus.alu_a << bus.alu_b[4:0];
            4'h6: bus.alu_result = bus.alu_a >> bus.alu_b[4:0];
            4'h7: bus.alu_result = $unsigned($signed(bus.alu_a) >>> bus.alu_b[4:0]);
            4'h8: bus.alu_bool = (bus.alu_a == bus.alu_b);
            4'h9: bus.alu_bool = (bus.alu_a != bus.alu_b);
            4'hA: bus.alu_bool = ($signed(bus.alu_a) >= $signed(bus.alu_b));
            4'hB: bus.alu_bool = ($signed(bus.alu_a) < $signed(bus.alu_b));
            default: bus.alu_bool = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h, want %08h", name, act, exp);
    endtask

    // Instruction-level semantics: what the retired instruction must produce.
    function automatic vec_t ref_model(input vec_t v);
        vec_t        e;
        logic [31:0] b;
        e     = v;
        e.res = 32'h0;
        e.wr  = 1'b0;
        e.tk  = 1'b0;
        e.br  = 1'b0;
        e.ill = 1'b0;
        case (v.opc)
            7'b0110011, 7'b0010011: begin
                b    = (v.opc == 7'b0110011) ? v.rs2 : v.imm;
                e.wr = 1'b1;
                case (v.f3)
                    3'd0: begin
                        if (v.opc == 7'b0110011 && v.f7) e.res = v.rs1 - b;
                        else                             e.res = v.rs1 + b;
                    end
                    3'd1: e.res = v.rs1 << b[4:0];
                    3'd4: e.res = v.rs1 ^ b;
                    3'd5: begin
                        if (v.f7) e.res = $unsigned($signed(v.rs1) >>> b[4:0]);
                        else      e.res = v.rs1 >> b[4:0];
                    end
                    3'd6: e.res = v.rs1 | b;
                    3'd7: e.res = v.rs1 & b;
                    default: e.ill = 1'b1;
                endcase
            end
            7'b0000011, 7'b1100111: begin
                e.res = v.rs1 + v.imm;
                e.wr  = 1'b1;
            end
            7'b0100011: e.res = v.rs1 + v.imm;
            7'b0110111: begin
                e.res = v.imm;
                e.wr  = 1'b1;
            end
            7'b1100011: begin
                e.br  = 1'b1;
                e.res = v.pc + v.imm;
                case (v.f3)
                    3'd0: e.tk = (v.rs1 == v.rs2);
                    3'd1: e.tk = (v.rs1 != v.rs2);
                    3'd4: e.tk = ($signed(v.rs1) < $signed(v.rs2));
                    3'd5: e.tk = ($signed(v.rs1) >= $signed(v.rs2));
                    default: e.ill = 1'b1;
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        if (e.ill) begin
            e.wr = 1'b0;
            e.br = 1'b0;
            e.tk = 1'b0;
        end
        return e;
    endfunction

    // Issue one instruction, follow it through the sequencer and retire it.
    task automatic run_one(input vec_t v, input bit chk_sel, input bit noise);
        int guard;
        int lat;
        guard = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready   = (v.hold == 0);
        bus.in_opcode   = v.opc;
        bus.in_funct3   = v.f3;
        bus.in_funct7_5 = v.f7;
        bus.in_rs1      = v.rs1;
        bus.in_rs2      = v.rs2;
        bus.in_imm      = v.imm;
        bus.in_pc       = v.pc;
        bus.in_rd       = v.rd;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid    = noise;
        bus.in_opcode   = 7'($urandom());
        bus.in_funct3   = 3'($urandom());
        bus.in_rs1      = $urandom();
        bus.in_rs2      = $urandom();
        bus.in_imm      = $urandom();
        bus.in_pc       = $urandom();
        @(negedge clk);
        if (chk_sel) chk("exec_sel", 32'(bus.alu_sel), 32'(v.sel));
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 8) begin
            if (chk_sel && v.br && lat == 2) chk("brtgt_sel", 32'(bus.alu_sel), 32'h0);
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), v.br ? 32'd3 : 32'd2);
        if (!v.ill) chk("result", bus.out_result, v.res);
        chk("rd", 32'(bus.out_rd), 32'(v.rd));
        chk("wr_en", 32'(bus.out_wr_en), 32'(v.wr));
        chk("br_taken", 32'(bus.out_br_taken), 32'(v.tk));
`ifdef EXEC_ILLEGAL_TRAP_EN
        chk("illegal", 32'(bus.out_illegal), 32'(v.ill));
`endif
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            chk("bp_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            if (!v.ill) chk("bp_result", bus.out_result, v.res);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("valid_drop", 32'(bus.out_valid), 32'd0);
        chk("ready_back", 32'(bus.in_ready), 32'd1);
    endtask

    vec_t vecs[17];
    vec_t rv;
    logic [6:0] opcs[8];

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_opcode = 7'h0;
        bus.in_funct3 = 3'h0;
        bus.in_funct7_5 = 1'b0;
        bus.in_rs1 = 32'h0;
        bus.in_rs2 = 32'h0;
        bus.in_imm = 32'h0;
        bus.in_pc = 32'h0;
        bus.in_rd = 5'd0;

        //           opc          f3    f7    rs1           rs2           imm           pc            rd  hold sel   res           wr    tk    br    ill
        vecs[0]  = '{7'b0110011, 3'd0, 1'b1, 32'd10,       32'd3,        32'h0,        32'h0,        5'd1, 0, 4'h1, 32'd7,        1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{7'b1100011, 3'd4, 1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFF0, 32'h100,      5'd0, 0, 4'hB, 32'hF0,       1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{7'b0010011, 3'd5, 1'b1, 32'h80000000, 32'h0,        32'd4,        32'h0,        5'd3, 5, 4'h7, 32'hF8000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{7'b0110011, 3'd2, 1'b0, 32'd1,        32'd2,        32'h0,        32'h0,        5'd4, 0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{7'b1100111, 3'd0, 1'b0, 32'hFFFFFFFC, 32'h0,        32'd8,        32'h0,        5'd1, 0, 4'h0, 32'h4,        1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{7'b0110111, 3'd5, 1'b0, 32'hDEADBEEF, 32'h0,        32'h12345000, 32'h0,        5'd7, 0, 4'h0, 32'h12345000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{7'b1100011, 3'd5, 1'b0, 32'h80000000, 32'd5,        32'h20,       32'h1000,     5'd0, 0, 4'hA, 32'h1020,     1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{7'b0100011, 3'd2, 1'b0, 32'h1000,     32'h55,       32'h10,       32'h0,        5'd9, 0, 4'h0, 32'h1010,     1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{7'b0010011, 3'd0, 1'b1, 32'd5,        32'h0,        32'd7,        32'h0,        5'd2, 0, 4'h0, 32'd12,       1'b1, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{7'b1100011, 3'd0, 1'b0, 32'hAB,       32'hAB,       32'd8,        32'hFFFFFFFC, 5'd0, 0, 4'h8, 32'h4,        1'b0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{7'b0110011, 3'd5, 1'b0, 32'h80000000, 32'd4,        32'h0,        32'h0,        5'd5, 0, 4'h6, 32'h08000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{7'b1100011, 3'd6, 1'b0, 32'd1,        32'd2,        32'd8,        32'h40,       5'd6, 0, 4'h0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{7'b1100011, 3'd1, 1'b0, 32'd7,        32'd7,        32'd4,        32'h200,      5'd0, 0, 4'h9, 32'h204,      1'b0, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{7'b0110011, 3'd7, 1'b0, 32'hF0F0,     32'hFF00,     32'h0,        32'h0,        5'd8, 0, 4'h2, 32'hF000,     1'b1, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{7'b0110011, 3'd4, 1'b0, 32'hFF,       32'h0F,       32'h0,        32'h0,        5'd10, 0, 4'h4, 32'hF0,      1'b1, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{7'b0110011, 3'd1, 1'b0, 32'd1,        32'h21,       32'h0,        32'h0,        5'd11, 0, 4'h5, 32'd2,       1'b1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{7'b1111111, 3'd0, 1'b0, 32'd3,        32'd4,        32'd5,        32'h0,        5'd12, 0, 4'h0, 32'h0,       1'b0, 1'b0, 1'b0, 1'b1};

        opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                 7'b1100111, 7'b0110111, 7'b1100011, 7'b0001111};

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_wr_en", 32'(bus.out_wr_en), 32'd0);
        chk("rst_out_br_taken", 32'(bus.out_br_taken), 32'd0);
        chk("rst_out_result", bus.out_result, 32'h0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_alu_sel", 32'(bus.alu_sel), 32'h0);
        chk("rst_alu_a", bus.alu_a, 32'h0);
        chk("rst_alu_b", bus.alu_b, 32'h0);
`ifdef EXEC_ILLEGAL_TRAP_EN
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 17; i++) run_one(vecs[i], 1'b1, 1'b0);

        // Asynchronous reset while the branch target pass is in flight.
        @(negedge clk);
        bus.in_opcode   = vecs[1].opc;
        bus.in_funct3   = vecs[1].f3;
        bus.in_funct7_5 = vecs[1].f7;
        bus.in_rs1      = vecs[1].rs1;
        bus.in_rs2      = vecs[1].rs2;
        bus.in_imm      = vecs[1].imm;
        bus.in_pc       = vecs[1].pc;
        bus.in_rd       = 5'd17;
        bus.in_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_brtgt_alu_a", bus.alu_a, 32'h100);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_alu_a", bus.alu_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_valid", 32'(bus.out_valid), 32'd0);
            chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        end

        // Randomized instructions against the reference model.
        for (int i = 0; i < 150; i++) begin
            rv.opc  = opcs[$urandom_range(7)];
            rv.f3   = 3'($urandom_range(7));
            rv.f7   = 1'($urandom_range(1));
            rv.rs1  = $urandom();
            rv.rs2  = ($urandom_range(3) == 0) ? rv.rs1 : $urandom();
            rv.imm  = $urandom();
            rv.pc   = $urandom();
            rv.rd   = 5'($urandom_range(31));
            rv.hold = $urandom_range(2);
            rv.sel  = 4'h0;
            rv      = ref_model(rv);
            run_one(rv, 1'b0, 1'($urandom_range(1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
